// File: rtl/parse_pkg.sv
// Shared constants, field-offset helpers and opcode encoding for the instruction parse queue.
package parse_pkg;

    localparam int OP_SIZE_DEF      = 4;
    localparam int PARAM_A_SIZE_DEF = 4;
    localparam int PARAM_B_SIZE_DEF = 4;
    localparam int DEPTH_DEF        = 4;
    localparam int NUM_OPS_DEF      = 8;

    typedef enum logic [OP_SIZE_DEF-1:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_STORE = 4'd2,
        OP_DENSE = 4'd3,
        OP_ACT   = 4'd4,
        OP_COST  = 4'd5,
        OP_SYNC  = 4'd6,
        OP_HALT  = 4'd7
    } op_e;

    function automatic int code_width(input int op_size, input int a_size, input int b_size);
        return op_size + a_size + b_size;
    endfunction

    // Lowest bit of the opcode field: everything below it is the cost field.
    function automatic int op_lsb(input int a_size, input int b_size);
        return a_size + b_size;
    endfunction

    function automatic int act_lsb(input int b_size);
        return b_size;
    endfunction

endpackage

// File: rtl/parse_fifo.sv
// Circular storage for decoded entries with wrap-around pointers and an occupancy counter.
module parse_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

    // Qualify requests: flush wins over both, and never overrun or underrun.
    always_comb begin
        do_push_s = push && !flush && !full;
        do_pop_s  = pop  && !flush && !empty;
    end

    // Pointers and occupancy; reset and flush both discard all entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH-1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage is intentionally not reset; validity is tracked by count_r alone.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head entry, forced to zero when nothing is queued.
    always_comb begin
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/parse_queue.sv
// Decodes instruction words at push time and queues the decoded fields for a consumer.
// Optional feature: define PARSE_ILLEGAL_CHECK_EN to flag and store out-of-range opcodes.
module parse_queue
    import parse_pkg::*;
#(
    parameter int OP_SIZE      = OP_SIZE_DEF,
    parameter int PARAM_A_SIZE = PARAM_A_SIZE_DEF,
    parameter int PARAM_B_SIZE = PARAM_B_SIZE_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int NUM_OPS      = NUM_OPS_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        flush,
    input  logic                                        code_valid,
    input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] code,
    output logic                                        code_ready,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [OP_SIZE-1:0]                          op,
    output logic [PARAM_A_SIZE-1:0]                     act_type,
    output logic [PARAM_B_SIZE-1:0]                     dense_type,
    output logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0]        cost_type,
    output logic                                        illegal,
    output logic [$clog2(DEPTH+1)-1:0]                  count
);

    localparam int CODE_W  = code_width(OP_SIZE, PARAM_A_SIZE, PARAM_B_SIZE);
    localparam int OP_LSB  = op_lsb(PARAM_A_SIZE, PARAM_B_SIZE);
    localparam int ACT_LSB = act_lsb(PARAM_B_SIZE);
`ifdef PARSE_ILLEGAL_CHECK_EN
    localparam int ENTRY_W = CODE_W + 1;
`else
    localparam int ENTRY_W = CODE_W;
`endif

    logic [OP_SIZE-1:0]      op_in_s;
    logic [PARAM_A_SIZE-1:0] act_in_s;
    logic [PARAM_B_SIZE-1:0] dense_in_s;
    logic [ENTRY_W-1:0]      entry_in_s;
    logic [ENTRY_W-1:0]      entry_out_s;
    logic                    full_s;
    logic                    empty_s;

    // Split the raw word; cost_type is rebuilt from act/dense so it is not stored twice.
    always_comb begin
        op_in_s    = code[CODE_W-1 -: OP_SIZE];
        act_in_s   = code[OP_LSB-1 -: PARAM_A_SIZE];
        dense_in_s = code[ACT_LSB-1:0];
`ifdef PARSE_ILLEGAL_CHECK_EN
        entry_in_s = {(32'(op_in_s) >= 32'(NUM_OPS)), op_in_s, act_in_s, dense_in_s};
`else
        entry_in_s = {op_in_s, act_in_s, dense_in_s};
`endif
    end

    assign code_ready = !full_s && !flush;
    assign out_valid  = !empty_s;

    parse_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (code_valid && code_ready),
        .pop   (out_valid && out_ready),
        .wdata (entry_in_s),
        .rdata (entry_out_s),
        .count (count),
        .full  (full_s),
        .empty (empty_s)
    );

    // Head fields; the fifo already zeroes its head when empty.
    always_comb begin
        op         = entry_out_s[CODE_W-1 -: OP_SIZE];
        act_type   = entry_out_s[OP_LSB-1 -: PARAM_A_SIZE];
        dense_type = entry_out_s[ACT_LSB-1:0];
        cost_type  = {act_type, dense_type};
`ifdef PARSE_ILLEGAL_CHECK_EN
        illegal    = entry_out_s[ENTRY_W-1];
`else
        illegal    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_parse_queue.sv
// Randomized and directed bench for parse_queue against a queue-based reference model.
module tb_parse_queue;

    localparam int OPW     = 4;
    localparam int AW      = 4;
    localparam int BW      = 4;
    localparam int DEPTH   = 4;
    localparam int NUM_OPS = 8;
    localparam int CW      = OPW + AW + BW;
    localparam int CNTW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            code_valid;
    logic [CW-1:0]   code;
    logic            code_ready;
    logic            out_valid;
    logic            out_ready;
    logic [OPW-1:0]  op;
    logic [AW-1:0]   act_type;
    logic [BW-1:0]   dense_type;
    logic [AW+BW-1:0] cost_type;
    logic            illegal;
    logic [CNTW-1:0] count;

    int model_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    parse_queue #(
        .OP_SIZE(OPW), .PARAM_A_SIZE(AW), .PARAM_B_SIZE(BW), .DEPTH(DEPTH), .NUM_OPS(NUM_OPS)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .code_valid(code_valid), .code(code),
        .code_ready(code_ready), .out_valid(out_valid), .out_ready(out_ready),
        .op(op), .act_type(act_type), .dense_type(dense_type), .cost_type(cost_type),
        .illegal(illegal), .count(count)
    );

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Expected head fields computed arithmetically from the raw word at the model's front.
    task automatic check_outputs(input logic fl);
        int head;
        int exp_ill;
        head    = (model_q.size() != 0) ? model_q[0] : 0;
        exp_ill = 0;
`ifdef PARSE_ILLEGAL_CHECK_EN
        exp_ill = (model_q.size() != 0 && (head / 256) >= NUM_OPS) ? 1 : 0;
`endif
        check_value("count",      32'(count),      32'(model_q.size()));
        check_value("out_valid",  32'(out_valid),  (model_q.size() != 0) ? 32'd1 : 32'd0);
        check_value("code_ready", 32'(code_ready), (model_q.size() < DEPTH && !fl) ? 32'd1 : 32'd0);
        check_value("op",         32'(op),         32'(head / 256));
        check_value("act_type",   32'(act_type),   32'((head / 16) % 16));
        check_value("dense_type", 32'(dense_type), 32'(head % 16));
        check_value("cost_type",  32'(cost_type),  32'(head % 256));
        check_value("illegal",    32'(illegal),    32'(exp_ill));
    endtask

    // One clock: drive, check pre-edge state, then advance the model by what the edge does.
    task automatic cycle(input logic v, input logic [CW-1:0] c, input logic r, input logic fl);
        bit accept;
        bit take;
        @(negedge clk);
        code_valid = v;
        code       = c;
        out_ready  = r;
        flush      = fl;
        #1;
        check_outputs(fl);
        accept = v && (model_q.size() < DEPTH) && !fl;
        take   = r && (model_q.size() != 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (take) void'(model_q.pop_front());
            if (accept) model_q.push_back(int'(c));
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        check_outputs(flush);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [CW-1:0] w;
        rst = 1'b1; flush = 1'b0; code_valid = 1'b0; code = '0; out_ready = 1'b0;
        #3;
        check_outputs(1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Single push into an empty queue, visible one cycle later.
        cycle(1'b1, 12'hA5C, 1'b0, 1'b0);
        cycle(1'b0, 12'h000, 1'b0, 1'b0);
        cycle(1'b0, 12'h000, 1'b1, 1'b0);
        cycle(1'b0, 12'h000, 1'b0, 1'b0);

        // Fill, offer a fifth word, then drain in order.
        for (int i = 0; i < 5; i++) cycle(1'b1, CW'(12'h111 * (i + 1)), 1'b0, 1'b0);
        cycle(1'b1, 12'hFFF, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 12'h000, 1'b1, 1'b0);

        // Steady push+pop at count=2 across pointer wrap.
        cycle(1'b1, 12'h321, 1'b0, 1'b0);
        cycle(1'b1, 12'h654, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            w = CW'($urandom);
            cycle(1'b1, w, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h000, 1'b1, 1'b0);

        // Opcode range boundary.
        cycle(1'b1, 12'h9AB, 1'b0, 1'b0);
        cycle(1'b1, 12'h7CD, 1'b0, 1'b0);
        cycle(1'b1, 12'h8EF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h000, 1'b1, 1'b0);

        // Flush with a concurrent push at count=3.
        for (int i = 0; i < 3; i++) cycle(1'b1, CW'(12'h2A0 + i), 1'b0, 1'b0);
        cycle(1'b1, 12'hBEE, 1'b1, 1'b1);
        cycle(1'b0, 12'h000, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle with entries queued, then reuse.
        cycle(1'b1, 12'h4C3, 1'b0, 1'b0);
        cycle(1'b1, 12'h5D2, 1'b0, 1'b0);
        code_valid = 1'b0;
        async_reset();
        cycle(1'b1, 12'h6E1, 1'b0, 1'b0);
        cycle(1'b0, 12'h000, 1'b1, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                code_valid = 1'b0;
                flush = 1'b0;
                async_reset();
            end else begin
                cycle(($urandom_range(99) < 60) ? 1'b1 : 1'b0, CW'($urandom),
                      ($urandom_range(99) < 50) ? 1'b1 : 1'b0,
                      ($urandom_range(29) == 0) ? 1'b1 : 1'b0);
            end
        end
        cycle(1'b0, 12'h000, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/parse_queue.md
PARSE_QUEUE -- requirements
Module: parse_queue

Interface
REQ-001 SHALL have parameter OP_SIZE, default 4, opcode field width.
REQ-002 SHALL have parameter PARAM_A_SIZE, default 4, activation-type field width.
REQ-003 SHALL have parameter PARAM_B_SIZE, default 4, dense-type field width.
REQ-004 SHALL have parameter DEPTH, default 4, decoded-instruction queue depth; a power of 2 and at least 2.
REQ-005 SHALL have parameter NUM_OPS, default 8, count of legal opcodes (0..NUM_OPS-1).
REQ-006 SHALL have port clk, input, 1 bit, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset, asynchronous, active-high.
REQ-008 SHALL have port flush, input, 1 bit, synchronous queue clear.
REQ-009 SHALL have port code_valid, input, 1 bit, instruction word present.
REQ-010 SHALL have port code, input, OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE bits, raw instruction word.
REQ-011 SHALL have port code_ready, output, 1 bit, queue can accept.
REQ-012 SHALL have port out_valid, output, 1 bit, decoded entry at head.
REQ-013 SHALL have port out_ready, input, 1 bit, consumer takes the head.
REQ-014 SHALL have port op, output, OP_SIZE bits, head opcode.
REQ-015 SHALL have port act_type, output, PARAM_A_SIZE bits, head activation type.
REQ-016 SHALL have port dense_type, output, PARAM_B_SIZE bits, head dense type.
REQ-017 SHALL have port cost_type, output, PARAM_A_SIZE+PARAM_B_SIZE bits, head cost type.
REQ-018 SHALL have port illegal, output, 1 bit, head opcode >= NUM_OPS.
REQ-019 SHALL have port count, output, $clog2(DEPTH+1) bits, occupancy.

Function
REQ-020 Field split SHALL be: op = code[MSB -: OP_SIZE]; act_type = next PARAM_A_SIZE bits below op; dense_type = code[PARAM_B_SIZE-1:0]; cost_type = code[PARAM_A_SIZE+PARAM_B_SIZE-1:0].
REQ-021 Decode SHALL be performed at push; each queue entry stores the decoded fields plus the illegal flag.
REQ-022 A push SHALL occur on a rising edge with code_valid && code_ready; a pop SHALL occur on a rising edge with out_valid && out_ready.
REQ-023 code_ready SHALL equal !full && !flush; no pass-through when full, even if a pop occurs in the same cycle.
REQ-024 out_valid SHALL equal (count != 0); outputs SHALL show the head entry and hold stable while out_valid && !out_ready.
REQ-025 Latency from push into an empty queue to out_valid SHALL be 1 cycle.
REQ-026 A simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and keep order.
REQ-027 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-028 When empty, op, act_type, dense_type, cost_type and illegal SHALL be 0.
REQ-029 flush SHALL clear count and pointers on the next edge, override a same-cycle push or pop, and drop the push.

Reset
REQ-030 rst high SHALL immediately force count=0, out_valid=0, all data outputs 0, illegal=0, and code_ready=1 once flush is low.
REQ-031 rst asserted mid-operation SHALL discard all queued entries; storage contents need not be cleared.

Configuration
REQ-032 With macro PARSE_ILLEGAL_CHECK_EN defined, illegal SHALL be computed per REQ-018 and stored per entry.
REQ-033 Without PARSE_ILLEGAL_CHECK_EN, illegal SHALL be tied 0 and no per-entry flag storage SHALL exist.

Structure
REQ-034 Package parse_pkg SHALL hold the default width constants, the field-offset functions, and the opcode enum (op_e).
REQ-035 Storage and pointers SHALL be a sub-module parse_fifo; field decode SHALL stay in parse_queue.

Verification
REQ-036 Defaults, push code=12'hA5C into an empty queue -> next cycle out_valid=1, op=4'hA, act_type=4'h5, dense_type=4'hC, cost_type=8'h5C.
REQ-037 Push 4 words with out_ready=0 -> count=4, code_ready=0; a fifth word offered is not accepted; pop 4 -> words return in push order, then out_valid=0.
REQ-038 count=2, push and pop on the same edge -> count stays 2; pointers wrap cleanly over 10 such cycles.
REQ-039 With PARSE_ILLEGAL_CHECK_EN defined, push op=4'h9 (NUM_OPS=8) -> illegal=1 at head; op=4'h7 -> illegal=0; without the macro, illegal stays 0.
REQ-040 count=3, assert flush together with code_valid -> next cycle count=0, out_valid=0, pushed word absent.
REQ-041 count=2, assert rst asynchronously mid-cycle -> out_valid=0 and outputs 0 before the next edge; after release, the queue accepts new words.
